// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
//   Shared definitions for the multi-cycle core controller:
//     - state_t      : controller states, FETCH through ILLEGAL
//     - opcode values for the supported instruction classes
//     - opc_e        : instruction class derived from the 7-bit opcode
//     - mux encodings for ALU A/B select, ALU op, result select and ImmSrc
//     - ctrl_t       : bundle of every control output produced per state
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

    // Controller states.
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        ILLEGAL  = 4'd11
    } state_t;

    // Opcodes (instr[6:0]).
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // Instruction class, so that every consumer decodes the opcode the same way.
    typedef enum logic [2:0] {
        OPC_LW,
        OPC_SW,
        OPC_R,
        OPC_I,
        OPC_BEQ,
        OPC_JAL,
        OPC_BAD
    } opc_e;

    // ALU A select.
    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RD1   = 2'b10
    } alu_src_a_e;

    // ALU B select.
    typedef enum logic [1:0] {
        SRCB_RD2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_e;

    // ALU operation class.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    // Result select.
    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_e;

    // Immediate format for the extender.
    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    // Every control output for one cycle.
    typedef struct packed {
        logic        mem_req;
        logic        mem_write;
        logic        adr_src;
        logic        ir_write;
        logic        pc_write;
        logic        reg_write;
        alu_src_a_e  alu_src_a;
        alu_src_b_e  alu_src_b;
        alu_op_e     alu_op;
        result_src_e result_src;
        imm_src_e    imm_src;
        logic        illegal;
    } ctrl_t;

    // Map an opcode onto its instruction class; unknown opcodes are OPC_BAD.
    function automatic opc_e classify(input logic [6:0] op);
        unique case (op)
            OP_LW:    return OPC_LW;
            OP_SW:    return OPC_SW;
            OP_RTYPE: return OPC_R;
            OP_ITYPE: return OPC_I;
            OP_BEQ:   return OPC_BEQ;
            OP_JAL:   return OPC_JAL;
            default:  return OPC_BAD;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_out_decode.sv
// -----------------------------------------------------------------------------
// mc_ctrl_out_decode
//   Purely combinational output map of the multi-cycle controller. Every
//   output is a function of the current state, qualified by mem_ready_i
//   (FETCH loads) and zero_i (branch), with ImmSrc chosen from the opcode in
//   DECODE and MEMADR. Anything not driven in a state stays 0.
//
//   Ports:
//     state_i      in   current controller state
//     op_i         in   opcode from the instruction register
//     zero_i       in   ALU zero flag
//     mem_ready_i  in   memory completes the current access this cycle
//     ctrl_o       out  full control bundle for this cycle
// -----------------------------------------------------------------------------
module mc_ctrl_out_decode
    import mc_ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic [6:0] op_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    opc_e opc;

    assign opc = classify(op_i);

    always_comb begin
        // NOTE: a full default before the case keeps every field assigned on
        // every path, so no latch is inferred for outputs a state leaves alone.
        ctrl_o = '0;

        unique case (state_i)
            FETCH: begin
                // PC+4 is computed on the ALU while the instruction is read;
                // IR/OldPC and PC load together when memory completes.
                ctrl_o.mem_req    = 1'b1;
                ctrl_o.adr_src    = 1'b0;
                ctrl_o.alu_src_a  = SRCA_PC;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.alu_op     = ALUOP_ADD;
                ctrl_o.result_src = RES_ALURESULT;
                ctrl_o.ir_write   = mem_ready_i;
                ctrl_o.pc_write   = mem_ready_i;
            end

            DECODE: begin
                // OldPC + imm precomputes the branch/jump target into ALUOut.
                ctrl_o.alu_src_a = SRCA_OLDPC;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
                unique case (opc)
                    OPC_SW:  ctrl_o.imm_src = IMM_S;
                    OPC_BEQ: ctrl_o.imm_src = IMM_B;
                    OPC_JAL: ctrl_o.imm_src = IMM_J;
                    default: ctrl_o.imm_src = IMM_I;
                endcase
            end

            MEMADR: begin
                ctrl_o.alu_src_a = SRCA_RD1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.imm_src   = (opc == OPC_SW) ? IMM_S : IMM_I;
            end

            MEMREAD: begin
                ctrl_o.mem_req    = 1'b1;
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.result_src = RES_ALUOUT;
            end

            MEMWB: begin
                ctrl_o.result_src = RES_DATA;
                ctrl_o.reg_write  = 1'b1;
            end

            MEMWRITE: begin
                ctrl_o.mem_req    = 1'b1;
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.result_src = RES_ALUOUT;
            end

            EXECR: begin
                ctrl_o.alu_src_a = SRCA_RD1;
                ctrl_o.alu_src_b = SRCB_RD2;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end

            EXECI: begin
                ctrl_o.alu_src_a = SRCA_RD1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_FUNCT;
                ctrl_o.imm_src   = IMM_I;
            end

            ALUWB: begin
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.reg_write  = 1'b1;
            end

            BEQ: begin
                // Compare RD1-RD2; the target already sits in ALUOut.
                ctrl_o.alu_src_a  = SRCA_RD1;
                ctrl_o.alu_src_b  = SRCB_RD2;
                ctrl_o.alu_op     = ALUOP_SUB;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.imm_src    = IMM_B;
                ctrl_o.pc_write   = zero_i;
            end

            JAL: begin
                // PC <- target from ALUOut while OldPC+4 is formed for rd.
                ctrl_o.alu_src_a  = SRCA_OLDPC;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.alu_op     = ALUOP_ADD;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.imm_src    = IMM_J;
                ctrl_o.pc_write   = 1'b1;
            end

            ILLEGAL: begin
                ctrl_o.illegal = 1'b1;
            end

            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//   Main controller of the multi-cycle core. Steps each instruction through
//   fetch, decode, execute, memory and writeback over one shared ALU and one
//   shared memory port, drives every datapath select and counts retired
//   instructions. Outputs are combinational from state (plus ready/zero
//   qualification) via mc_ctrl_out_decode.
//
//   Ports:
//     clk_i         in   clock
//     rst_ni        in   asynchronous active-low reset
//     op_i          in   opcode from the instruction register
//     zero_i        in   ALU zero flag
//     mem_ready_i   in   memory completes the current access this cycle
//     mem_req_o     out  memory access request
//     mem_write_o   out  memory write enable
//     adr_src_o     out  address select: 0=PC, 1=Result
//     ir_write_o    out  IR and OldPC load
//     pc_write_o    out  PC load
//     reg_write_o   out  register file write
//     alu_src_a_o   out  ALU A select: 00=PC, 01=OldPC, 10=RD1
//     alu_src_b_o   out  ALU B select: 00=RD2, 01=ImmExt, 10=4
//     alu_op_o      out  00=add, 01=sub, 10=funct decode
//     result_src_o  out  00=ALUOut, 01=Data, 10=ALUResult
//     imm_src_o     out  00=I, 01=S, 10=B, 11=J
//     illegal_o     out  one-cycle pulse on an unsupported opcode
//     instret_o     out  retired instruction count (wraps)
// -----------------------------------------------------------------------------
module multicycle_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OP_WIDTH  = 7,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [OP_WIDTH-1:0]  op_i,
    input  logic                 zero_i,
    input  logic                 mem_ready_i,
    output logic                 mem_req_o,
    output logic                 mem_write_o,
    output logic                 adr_src_o,
    output logic                 ir_write_o,
    output logic                 pc_write_o,
    output logic                 reg_write_o,
    output logic [1:0]           alu_src_a_o,
    output logic [1:0]           alu_src_b_o,
    output logic [1:0]           alu_op_o,
    output logic [1:0]           result_src_o,
    output logic [1:0]           imm_src_o,
    output logic                 illegal_o,
    output logic [CNT_WIDTH-1:0] instret_o
);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] instret_q;
    logic                 retire;
    logic [6:0]           opcode;
    ctrl_t                ctrl;

    // The opcode field is instr[6:0]; OP_WIDTH is kept at 7.
    assign opcode = op_i;

    // ------------------------------------------------------------------
    // Next state and retire strobe
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: combinational logic uses blocking '=' so later statements see
        // the defaults just set; clocked state below uses '<=' only.
        state_d = state_q;
        retire  = 1'b0;

        unique case (state_q)
            FETCH:    if (mem_ready_i) state_d = DECODE;

            DECODE: begin
                unique case (classify(opcode))
                    OPC_LW, OPC_SW: state_d = MEMADR;
                    OPC_R:          state_d = EXECR;
                    OPC_I:          state_d = EXECI;
                    OPC_BEQ:        state_d = BEQ;
                    OPC_JAL:        state_d = JAL;
                    default:        state_d = ILLEGAL;
                endcase
            end

            MEMADR:   state_d = (classify(opcode) == OPC_SW) ? MEMWRITE : MEMREAD;

            MEMREAD:  if (mem_ready_i) state_d = MEMWB;

            MEMWB: begin
                state_d = FETCH;
                retire  = 1'b1;
            end

            MEMWRITE: begin
                if (mem_ready_i) begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end
            end

            EXECR, EXECI: state_d = ALUWB;

            ALUWB, BEQ: begin
                state_d = FETCH;
                retire  = 1'b1;
            end

            // JAL retires through ALUWB when rd is written.
            JAL:      state_d = ALUWB;

            ILLEGAL:  state_d = FETCH;

            default:  state_d = FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // State and retired-instruction counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= FETCH;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instret_q <= instret_q + CNT_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output map
    // ------------------------------------------------------------------
    mc_ctrl_out_decode u_out_decode (
        .state_i     (state_q),
        .op_i        (opcode),
        .zero_i      (zero_i),
        .mem_ready_i (mem_ready_i),
        .ctrl_o      (ctrl)
    );

    // The state register already reads FETCH while rst_ni is low, so the
    // selects show FETCH values; strobes are forced off so nothing fires
    // before the first real cycle.
    assign mem_req_o    = ctrl.mem_req   & rst_ni;
    assign mem_write_o  = ctrl.mem_write & rst_ni;
    assign ir_write_o   = ctrl.ir_write  & rst_ni;
    assign pc_write_o   = ctrl.pc_write  & rst_ni;
    assign reg_write_o  = ctrl.reg_write & rst_ni;
    assign illegal_o    = ctrl.illegal   & rst_ni;

    assign adr_src_o    = ctrl.adr_src;
    assign alu_src_a_o  = ctrl.alu_src_a;
    assign alu_src_b_o  = ctrl.alu_src_b;
    assign alu_op_o     = ctrl.alu_op;
    assign result_src_o = ctrl.result_src;
    assign imm_src_o    = ctrl.imm_src;

    assign instret_o    = instret_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
//   Table-driven check of the multi-cycle controller: each row gives the
//   inputs for one cycle, the expected packed control outputs for that cycle
//   and the expected retired count. A hand-written sequence then drops reset
//   in the middle of a load's memory read.
//
//   Packed output order (17 bits):
//     {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
//      alu_src_a[1:0], alu_src_b[1:0], alu_op[1:0], result_src[1:0],
//      imm_src[1:0], illegal}
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

    // Opcodes
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    // Expected output words, one per state flavour
    //                                  rq wr ad ir pc rg  A  B  op rs im il
    localparam logic [16:0] E_FWAIT = 17'b1_0_0_0_0_0_00_10_00_10_00_0;
    localparam logic [16:0] E_FGO   = 17'b1_0_0_1_1_0_00_10_00_10_00_0;
    localparam logic [16:0] E_DEC00 = 17'b0_0_0_0_0_0_01_01_00_00_00_0;
    localparam logic [16:0] E_DEC01 = 17'b0_0_0_0_0_0_01_01_00_00_01_0;
    localparam logic [16:0] E_DEC10 = 17'b0_0_0_0_0_0_01_01_00_00_10_0;
    localparam logic [16:0] E_DEC11 = 17'b0_0_0_0_0_0_01_01_00_00_11_0;
    localparam logic [16:0] E_MA00  = 17'b0_0_0_0_0_0_10_01_00_00_00_0;
    localparam logic [16:0] E_MA01  = 17'b0_0_0_0_0_0_10_01_00_00_01_0;
    localparam logic [16:0] E_MRD   = 17'b1_0_1_0_0_0_00_00_00_00_00_0;
    localparam logic [16:0] E_MWB   = 17'b0_0_0_0_0_1_00_00_00_01_00_0;
    localparam logic [16:0] E_MWR   = 17'b1_1_1_0_0_0_00_00_00_00_00_0;
    localparam logic [16:0] E_EXR   = 17'b0_0_0_0_0_0_10_00_10_00_00_0;
    localparam logic [16:0] E_EXI   = 17'b0_0_0_0_0_0_10_01_10_00_00_0;
    localparam logic [16:0] E_AWB   = 17'b0_0_0_0_0_1_00_00_00_00_00_0;
    localparam logic [16:0] E_BEQ1  = 17'b0_0_0_0_1_0_10_00_01_00_10_0;
    localparam logic [16:0] E_BEQ0  = 17'b0_0_0_0_0_0_10_00_01_00_10_0;
    localparam logic [16:0] E_JAL   = 17'b0_0_0_0_1_0_01_10_00_00_11_0;
    localparam logic [16:0] E_ILL   = 17'b0_0_0_0_0_0_00_00_00_00_00_1;
    localparam logic [16:0] E_RST   = 17'b0_0_0_0_0_0_00_10_00_10_00_0;

    typedef struct {
        logic [6:0]  op;
        logic        zero;
        logic        rdy;
        logic [16:0] exp;
        logic [31:0] cnt;
    } vec_t;

    logic        clk_i;
    logic        rst_ni;
    logic [6:0]  op_i;
    logic        zero_i;
    logic        mem_ready_i;
    logic        mem_req_o, mem_write_o, adr_src_o, ir_write_o;
    logic        pc_write_o, reg_write_o, illegal_o;
    logic [1:0]  alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o, imm_src_o;
    logic [31:0] instret_o;
    logic [16:0] act;

    int   n_checks;
    int   n_errors;
    vec_t vecs[$];

    multicycle_control_fsm #(
        .OP_WIDTH  (7),
        .CNT_WIDTH (32)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .op_i         (op_i),
        .zero_i       (zero_i),
        .mem_ready_i  (mem_ready_i),
        .mem_req_o    (mem_req_o),
        .mem_write_o  (mem_write_o),
        .adr_src_o    (adr_src_o),
        .ir_write_o   (ir_write_o),
        .pc_write_o   (pc_write_o),
        .reg_write_o  (reg_write_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .alu_op_o     (alu_op_o),
        .result_src_o (result_src_o),
        .imm_src_o    (imm_src_o),
        .illegal_o    (illegal_o),
        .instret_o    (instret_o)
    );

    assign act = {mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o,
                  reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o,
                  result_src_o, imm_src_o, illegal_o};

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic add(input logic [6:0] op, input logic zero, input logic rdy,
                       input logic [16:0] exp, input logic [31:0] cnt);
        vec_t v;
        v.op   = op;
        v.zero = zero;
        v.rdy  = rdy;
        v.exp  = exp;
        v.cnt  = cnt;
        vecs.push_back(v);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        op_i        = LW;
        zero_i      = 1'b0;
        mem_ready_i = 1'b0;
        rst_ni      = 1'b1;

        // ---------------- stimulus table ----------------
        // idle fetch, memory not ready
        add(LW, 0, 0, E_FWAIT, 0);
        // lw, zero-wait: 5 cycles
        add(LW, 0, 1, E_FGO,   0);
        add(LW, 0, 1, E_DEC00, 0);
        add(LW, 0, 1, E_MA00,  0);
        add(LW, 0, 1, E_MRD,   0);
        add(LW, 0, 1, E_MWB,   0);
        // sw, three wait cycles in MEMWRITE
        add(SW, 0, 1, E_FGO,   1);
        add(SW, 0, 1, E_DEC01, 1);
        add(SW, 0, 1, E_MA01,  1);
        add(SW, 0, 0, E_MWR,   1);
        add(SW, 0, 0, E_MWR,   1);
        add(SW, 0, 0, E_MWR,   1);
        add(SW, 0, 1, E_MWR,   1);
        // beq taken
        add(BQ, 1, 1, E_FGO,   2);
        add(BQ, 1, 1, E_DEC10, 2);
        add(BQ, 1, 1, E_BEQ1,  2);
        // beq not taken
        add(BQ, 0, 1, E_FGO,   3);
        add(BQ, 0, 1, E_DEC10, 3);
        add(BQ, 0, 1, E_BEQ0,  3);
        // jal (zero_i high must not matter)
        add(JL, 1, 1, E_FGO,   4);
        add(JL, 1, 1, E_DEC11, 4);
        add(JL, 1, 1, E_JAL,   4);
        add(JL, 1, 1, E_AWB,   4);
        // illegal opcode: one-cycle pulse, no retire
        add(BAD, 0, 1, E_FGO,   5);
        add(BAD, 0, 1, E_DEC00, 5);
        add(BAD, 0, 1, E_ILL,   5);
        // R-type
        add(RT, 0, 1, E_FGO,   5);
        add(RT, 0, 1, E_DEC00, 5);
        add(RT, 0, 1, E_EXR,   5);
        add(RT, 0, 1, E_AWB,   5);
        // I-type
        add(IT, 0, 1, E_FGO,   6);
        add(IT, 0, 1, E_DEC00, 6);
        add(IT, 0, 1, E_EXI,   6);
        add(IT, 0, 1, E_AWB,   6);
        // lw with fetch wait, read wait, ready low outside memory states
        add(LW, 0, 0, E_FWAIT, 7);
        add(LW, 0, 1, E_FGO,   7);
        add(LW, 1, 0, E_DEC00, 7);
        add(LW, 1, 0, E_MA00,  7);
        add(LW, 0, 0, E_MRD,   7);
        add(LW, 0, 1, E_MRD,   7);
        add(LW, 0, 0, E_MWB,   7);
        add(LW, 0, 0, E_FWAIT, 8);

        // ---------------- reset ----------------
        #1 rst_ni = 1'b0;
        #1;
        check("reset_out", {15'd0, act}, {15'd0, E_RST});
        check("reset_cnt", instret_o, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // ---------------- table run ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            op_i        = vecs[i].op;
            zero_i      = vecs[i].zero;
            mem_ready_i = vecs[i].rdy;
            #1;
            check($sformatf("row%0d_out", i), {15'd0, act}, {15'd0, vecs[i].exp});
            check($sformatf("row%0d_cnt", i), instret_o, vecs[i].cnt);
            @(negedge clk_i);
        end

        // ---------------- reset dropped mid-MEMREAD ----------------
        op_i        = LW;
        zero_i      = 1'b0;
        mem_ready_i = 1'b1;
        #1;
        check("abort_fetch", {15'd0, act}, {15'd0, E_FGO});
        @(negedge clk_i);          // DECODE
        @(negedge clk_i);          // MEMADR
        @(negedge clk_i);          // MEMREAD
        mem_ready_i = 1'b0;
        #1;
        check("abort_memread", {15'd0, act}, {15'd0, E_MRD});
        check("abort_cnt_before", instret_o, 32'd8);
        #2 rst_ni = 1'b0;
        #1;
        check("abort_rst_out", {15'd0, act}, {15'd0, E_RST});
        check("abort_rst_cnt", instret_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("after_rst_fetch", {15'd0, act}, {15'd0, E_FWAIT});
        check("after_rst_cnt", instret_o, 32'd0);
        @(negedge clk_i);
        mem_ready_i = 1'b1;
        #1;
        check("after_rst_fetch_go", {15'd0, act}, {15'd0, E_FGO});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main controller for the multi-cycle variant of the core. It replaces the single-cycle combinational control decode.
- Sequences fetch, decode, execute, memory and writeback over one shared ALU and one shared memory port.
- Drives every datapath mux select, including ImmSrc for the immediate extender.
- Waits on a memory ready handshake, and counts retired instructions.

Parameters:
- OP_WIDTH, 7, opcode field width (instr[6:0]).
- CNT_WIDTH, 32, retired-instruction counter width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- op_i  in  OP_WIDTH  opcode from the instruction register.
- zero_i  in  1  ALU zero flag.
- mem_ready_i  in  1  memory has completed the current access this cycle.
- mem_req_o  out  1  memory access request.
- mem_write_o  out  1  memory write enable.
- adr_src_o  out  1  address select: 0=PC, 1=Result.
- ir_write_o  out  1  instruction register and OldPC load.
- pc_write_o  out  1  PC load.
- reg_write_o  out  1  register file write.
- alu_src_a_o  out  2  ALU A select: 00=PC, 01=OldPC, 10=RD1.
- alu_src_b_o  out  2  ALU B select: 00=RD2, 01=ImmExt, 10=const 4.
- alu_op_o  out  2  00=add, 01=sub, 10=funct decode.
- result_src_o  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult.
- imm_src_o  out  2  immediate format: 00=I, 01=S, 10=B, 11=J.
- illegal_o  out  1  one-cycle pulse on an unsupported opcode.
- instret_o  out  CNT_WIDTH  retired instruction count.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_ni).
  - State goes to FETCH and instret_o goes to 0.
  - While rst_ni=0, all strobes are 0: mem_req, mem_write, ir_write, pc_write, reg_write, illegal.
  - While rst_ni=0, selects take their FETCH values.
  - Assertion mid-instruction abandons the instruction immediately; no count is taken.
- Outputs are combinational from state plus zero_i, mem_ready_i and op_i (Moore, except for the ready/zero qualification). Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_req=1, adr_src=0, A=00, B=10, alu_op=00, result_src=10.
  - ir_write = pc_write = mem_ready_i.
  - Stay in FETCH until mem_ready_i=1, then go to DECODE.
- DECODE:
  - Outputs: A=01, B=01, alu_op=00 (precomputes the branch target).
  - imm_src by opcode: sw=01, beq=10, jal=11, otherwise 00.
  - Next state by opcode: 0000011 lw or 0100011 sw -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL; any other -> ILLEGAL.
- MEMADR:
  - Outputs: A=10, B=01, alu_op=00; imm_src = 01 for sw, 00 for lw.
  - Next: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1, result_src=00. Stay until ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1; then FETCH; retire.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00. Stay until ready, then go to FETCH; retire on exit.
- EXECR: A=10, B=00, alu_op=10; then ALUWB.
- EXECI: A=10, B=01, alu_op=10, imm_src=00; then ALUWB.
- ALUWB: result_src=00, reg_write=1; then FETCH; retire.
- BEQ:
  - Outputs: A=10, B=00, alu_op=01, result_src=00, imm_src=10.
  - pc_write = zero_i; then FETCH; retire.
- JAL: A=01, B=10, alu_op=00, result_src=00, imm_src=11, pc_write=1; then ALUWB.
- ILLEGAL: illegal_o=1 for one cycle; then FETCH; no retire.
- Latency with zero-wait memory (cycles, FETCH to FETCH):
  - lw=5, sw=4, R/I=4, beq=3, jal=4.
  - Each extra wait cycle adds 1 per memory state.
- instret_o increments by 1 on every retire transition and wraps modulo 2^CNT_WIDTH.
- mem_ready_i is ignored outside FETCH, MEMREAD and MEMWRITE.
- op_i is sampled only in DECODE and MEMADR; the IR is stable from the end of FETCH.

Decomposition:
- Shared package `mc_ctrl_pkg` holds:
  - state enum state_t (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, ILLEGAL);
  - opcode localparams;
  - mux encodings for imm_src, alu_src_a/b, result_src and alu_op.
- One natural sub-module, `mc_ctrl_out_decode`: purely combinational state/op/zero/ready -> output map. It keeps the FSM register and counter in the top module.

Test Plan:
- lw (op 0000011), mem_ready_i always 1:
  - states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH;
  - reg_write=1 only in cycle 5; result_src=01 there;
  - instret 0->1.
- sw (op 0100011), mem_ready_i low for 3 cycles in MEMWRITE:
  - mem_write=1 for 4 cycles;
  - imm_src=01 in DECODE and MEMADR;
  - instret increments once, on exit.
- beq (op 1100011): zero_i=1 -> pc_write=1 in BEQ with imm_src=10; zero_i=0 -> pc_write=0. Both cases return to FETCH after 3 cycles.
- jal (op 1101111):
  - DECODE imm_src=11;
  - JAL asserts pc_write=1 with A=01, B=10;
  - then ALUWB with reg_write=1.
- Illegal op 1111111: illegal_o pulses exactly one cycle after DECODE, next state is FETCH, and instret is unchanged.
- rst_ni dropped asynchronously mid-MEMREAD:
  - all strobes go to 0 immediately and instret_o=0;
  - after release, first cycle is FETCH with mem_req=1.
